// File: rtl/accum_feeder_if.sv
// Bundle of the sample stream, accumulator control and result handshake
// signals shared between accum_feeder and its environment.
interface accum_feeder_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  logic [DATA_W-1:0]      in_data;
  logic                   in_last;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      acc_data;
  logic                   acc_enable;
  logic                   acc_clear;
  logic [DATA_W-1:0]      acc_accum;
  logic [DATA_W-1:0]      res_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [$clog2(DEPTH):0] fifo_count;

  modport master (
    output in_data, in_last, in_valid, acc_accum, res_ready,
    input  in_ready, acc_data, acc_enable, acc_clear, res_data, res_valid, fifo_count
  );

  modport slave (
    input  in_data, in_last, in_valid, acc_accum, res_ready,
    output in_ready, acc_data, acc_enable, acc_clear, res_data, res_valid, fifo_count
  );
endinterface

// File: rtl/accum_feeder.sv
// Buffers a framed sample stream, feeds it to the accumulator and captures
// each frame sum into a valid/ready result slot.
//   state   | meaning
//   S_ISSUE | pop FIFO beats into the accumulator until a last beat leaves
//   S_WAIT  | let the accumulator settle, capture once the slot is free
//   S_CLEAR | acc_clear high for one cycle; next frame starts from zero
module accum_feeder #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int ACC_LAT    = 1,
  parameter bit AUTO_CLEAR = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  accum_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ACC_LAT + 1);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W:0]   r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_acc_data, r_res_data;
  logic              r_acc_enable, r_acc_clear, r_res_valid;
  logic              w_full, w_ready, w_push, w_pop, w_capture;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_last;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_ready = reset_n && !w_full;
  assign w_push  = bus.in_valid && w_ready;
  assign {w_head_last, w_head_data} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.in_last, bus.in_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_ISSUE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_ISSUE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_head_last) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CW'(ACC_LAT);
          end
        end
      end
      S_WAIT: begin
        // Holding here with the counter at zero is safe: nothing is enabled,
        // so the accumulator sum cannot move while the slot is occupied.
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (!r_res_valid || bus.res_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = AUTO_CLEAR ? S_CLEAR : S_ISSUE;
        end
      end
      S_CLEAR: w_state_nxt = S_ISSUE;
      default: w_state_nxt = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_data   <= '0;
      r_acc_enable <= 1'b0;
      r_acc_clear  <= 1'b0;
      r_res_data   <= '0;
      r_res_valid  <= 1'b0;
    end else begin
      r_acc_enable <= w_pop;
      if (w_pop) r_acc_data <= w_head_data;
      r_acc_clear  <= w_capture && AUTO_CLEAR;
      if (w_capture) begin
        r_res_data  <= bus.acc_accum;
        r_res_valid <= 1'b1;
      end else if (bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.acc_data   = r_acc_data;
  assign bus.acc_enable = r_acc_enable;
  assign bus.acc_clear  = r_acc_clear;
  assign bus.res_data   = r_res_data;
  assign bus.res_valid  = r_res_valid;
  assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_accum_feeder.sv
// Directed bench for accum_feeder: two instances (ACC_LAT=1 with auto clear,
// ACC_LAT=3 without) each driving a behavioural accumulator.
module tb_accum_feeder;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accum_feeder_if #(.DATA_W(DW), .DEPTH(8)) ba ();
  accum_feeder_if #(.DATA_W(DW), .DEPTH(8)) bb ();

  accum_feeder #(.DATA_W(DW), .DEPTH(8), .ACC_LAT(1), .AUTO_CLEAR(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ba.slave));
  accum_feeder #(.DATA_W(DW), .DEPTH(8), .ACC_LAT(3), .AUTO_CLEAR(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bb.slave));

  // accumulator with one edge of latency
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)          ba.acc_accum <= '0;
    else if (ba.acc_clear) ba.acc_accum <= '0;
    else if (ba.acc_enable) ba.acc_accum <= ba.acc_accum + ba.acc_data;
  end

  // accumulator with three edges of latency: two delay stages then the add
  logic [DW+1:0] b_d1, b_d2;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_d1 <= '0;
      b_d2 <= '0;
      bb.acc_accum <= '0;
    end else begin
      b_d1 <= {bb.acc_clear, bb.acc_enable, bb.acc_data};
      b_d2 <= b_d1;
      if (b_d2[DW+1])    bb.acc_accum <= '0;
      else if (b_d2[DW]) bb.acc_accum <= bb.acc_accum + b_d2[DW-1:0];
    end
  end

  int a_en_data[$], a_en_cyc[$], a_res[$], a_clr_cyc[$];
  int a_valid_cyc = 0;
  int a_max_cnt = 0;
  int b_en_cyc[$], b_res[$], b_rise[$];
  int b_clr_cnt = 0;
  int b_valid_cyc = 0;
  logic b_prev_valid = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (ba.acc_enable) begin
        a_en_data.push_back(int'(ba.acc_data));
        a_en_cyc.push_back(cyc);
      end
      if (ba.acc_clear) a_clr_cyc.push_back(cyc);
      if (ba.res_valid) a_valid_cyc++;
      if (ba.res_valid && ba.res_ready) a_res.push_back(int'(ba.res_data));
      if (int'(ba.fifo_count) > a_max_cnt) a_max_cnt = int'(ba.fifo_count);
      if (bb.acc_enable) b_en_cyc.push_back(cyc);
      if (bb.acc_clear) b_clr_cnt++;
      if (bb.res_valid) b_valid_cyc++;
      if (bb.res_valid && !b_prev_valid) b_rise.push_back(cyc);
      if (bb.res_valid && bb.res_ready) b_res.push_back(int'(bb.res_data));
    end
    b_prev_valid = bb.res_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    a_en_data.delete(); a_en_cyc.delete(); a_res.delete(); a_clr_cyc.delete();
    a_valid_cyc = 0;
    a_max_cnt = 0;
  endtask

  // offer one beat and hold it until accepted
  task automatic send_a(input int d, input logic l);
    int  n;
    logic acc;
    n = 0;
    ba.in_data = DW'(d); ba.in_last = l; ba.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = ba.in_ready;
      step();
      if (acc) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL send_a_timeout beat=%0d not accepted within %0d cycles", d, n);
        break;
      end
    end
    ba.in_valid = 1'b0;
  endtask

  task automatic send_b(input int d, input logic l);
    int  n;
    logic acc;
    n = 0;
    bb.in_data = DW'(d); bb.in_last = l; bb.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = bb.in_ready;
      step();
      if (acc) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL send_b_timeout beat=%0d not accepted within %0d cycles", d, n);
        break;
      end
    end
    bb.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (ba.acc_enable !== 1'b0) begin bad++; $display("FAIL rst_enable got=%b want=0", ba.acc_enable); end
    total++; if (ba.acc_clear !== 1'b0) begin bad++; $display("FAIL rst_clear got=%b want=0", ba.acc_clear); end
    total++; if (ba.acc_data !== '0) begin bad++; $display("FAIL rst_acc_data got=%0d want=0", ba.acc_data); end
    total++; if (ba.res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b want=0", ba.res_valid); end
    total++; if (ba.res_data !== '0) begin bad++; $display("FAIL rst_res_data got=%0d want=0", ba.res_data); end
    total++; if (ba.fifo_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", ba.fifo_count); end
    total++; if (ba.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", ba.in_ready); end
    wait_cycles(2);
    reset_n = 1'b1;
    step();
    total++; if (ba.in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b want=1", ba.in_ready); end
  endtask

  task automatic test_single_frame();
    ba.res_ready = 1'b1;
    clear_logs();
    send_a(1, 1'b0); send_a(2, 1'b0); send_a(3, 1'b1);
    wait_cycles(12);
    total++;
    if (a_en_data.size() != 3) begin
      bad++; $display("FAIL single_en_count got=%0d want=3", a_en_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (a_en_data[i] != i + 1) begin bad++; $display("FAIL single_en_data idx=%0d got=%0d want=%0d", i, a_en_data[i], i + 1); end
      end
      total++; if (a_en_cyc[2] - a_en_cyc[0] != 2) begin bad++; $display("FAIL single_en_contig got=%0d want=2", a_en_cyc[2] - a_en_cyc[0]); end
      total++;
      if (a_clr_cyc.size() != 1) begin bad++; $display("FAIL single_clr_count got=%0d want=1", a_clr_cyc.size()); end
      else if (a_clr_cyc[0] - a_en_cyc[2] != 2) begin bad++; $display("FAIL single_clr_delay got=%0d want=2", a_clr_cyc[0] - a_en_cyc[2]); end
    end
    total++;
    if (a_res.size() != 1) begin bad++; $display("FAIL single_res_count got=%0d want=1", a_res.size()); end
    else if (a_res[0] != 6) begin bad++; $display("FAIL single_res got=%0d want=6", a_res[0]); end
    total++; if (a_valid_cyc != 1) begin bad++; $display("FAIL single_valid_cycles got=%0d want=1", a_valid_cyc); end
    total++; if (ba.acc_data !== 32'd3) begin bad++; $display("FAIL single_data_hold got=%0d want=3", ba.acc_data); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    send_a(5, 1'b0); send_a(5, 1'b1); send_a(7, 1'b1);
    wait_cycles(15);
    total++;
    if (a_res.size() != 2) begin bad++; $display("FAIL b2b_res_count got=%0d want=2", a_res.size()); end
    else begin
      total++; if (a_res[0] != 10) begin bad++; $display("FAIL b2b_res0 got=%0d want=10", a_res[0]); end
      total++; if (a_res[1] != 7) begin bad++; $display("FAIL b2b_res1 got=%0d want=7", a_res[1]); end
    end
    total++;
    if (a_en_cyc.size() != 3 || a_clr_cyc.size() != 2) begin
      bad++; $display("FAIL b2b_counts en=%0d clr=%0d want en=3 clr=2", a_en_cyc.size(), a_clr_cyc.size());
    end else begin
      total++;
      if (!(a_clr_cyc[0] > a_en_cyc[1] && a_clr_cyc[0] < a_en_cyc[2])) begin
        bad++; $display("FAIL b2b_clr_between clr=%0d en1=%0d en2=%0d", a_clr_cyc[0], a_en_cyc[1], a_en_cyc[2]);
      end
      total++; if (a_en_cyc[2] - a_en_cyc[1] != 4) begin bad++; $display("FAIL b2b_gap got=%0d want=4", a_en_cyc[2] - a_en_cyc[1]); end
    end
  endtask

  task automatic test_result_backpressure();
    ba.res_ready = 1'b0;
    clear_logs();
    send_a(1, 1'b1); send_a(2, 1'b1);
    wait_cycles(20);
    total++; if (ba.res_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", ba.res_valid); end
    total++; if (ba.res_data !== 32'd1) begin bad++; $display("FAIL bp_hold_data got=%0d want=1", ba.res_data); end
    total++; if (a_en_data.size() != 2) begin bad++; $display("FAIL bp_en_count got=%0d want=2", a_en_data.size()); end
    total++; if (ba.acc_enable !== 1'b0) begin bad++; $display("FAIL bp_stall_enable got=%b want=0", ba.acc_enable); end
    ba.res_ready = 1'b1;
    wait_cycles(10);
    total++;
    if (a_res.size() != 2) begin bad++; $display("FAIL bp_res_count got=%0d want=2", a_res.size()); end
    else if (a_res[0] != 1 || a_res[1] != 2) begin bad++; $display("FAIL bp_res got=%0d,%0d want=1,2", a_res[0], a_res[1]); end
    total++; if (ba.res_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid got=%b want=0", ba.res_valid); end
  endtask

  task automatic test_fifo_full();
    ba.res_ready = 1'b0;
    clear_logs();
    send_a(3, 1'b1); send_a(4, 1'b1);
    wait_cycles(15);
    total++; if (ba.res_data !== 32'd3) begin bad++; $display("FAIL full_pre_res got=%0d want=3", ba.res_data); end
    for (int i = 0; i < 8; i++) send_a(10 + i, 1'b0);
    total++; if (ba.fifo_count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", ba.fifo_count); end
    total++; if (ba.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", ba.in_ready); end
    fork
      send_a(18, 1'b1);
      begin
        wait_cycles(5);
        total++; if (ba.in_ready !== 1'b0 || ba.fifo_count !== 4'd8) begin
          bad++; $display("FAIL full_held in_ready=%b count=%0d want 0 and 8", ba.in_ready, ba.fifo_count);
        end
        ba.res_ready = 1'b1;
      end
    join
    wait_cycles(40);
    total++; if (a_max_cnt != 8) begin bad++; $display("FAIL full_max_count got=%0d want=8", a_max_cnt); end
    total++;
    if (a_res.size() != 3) begin bad++; $display("FAIL full_res_count got=%0d want=3", a_res.size()); end
    else if (a_res[0] != 3 || a_res[1] != 4 || a_res[2] != 126) begin
      bad++; $display("FAIL full_res got=%0d,%0d,%0d want=3,4,126", a_res[0], a_res[1], a_res[2]);
    end
    total++; if (a_en_data.size() != 11) begin bad++; $display("FAIL full_en_count got=%0d want=11", a_en_data.size()); end
  endtask

  task automatic test_reset_mid_frame();
    ba.res_ready = 1'b1;
    clear_logs();
    send_a(4, 1'b0); send_a(4, 1'b0);
    #3;
    total++; if (ba.acc_enable !== 1'b1 || ba.fifo_count !== 4'd1) begin
      bad++; $display("FAIL mid_pre enable=%b count=%0d want 1 and 1", ba.acc_enable, ba.fifo_count);
    end
    reset_n = 1'b0;
    #1;
    total++; if (ba.acc_enable !== 1'b0 || ba.acc_clear !== 1'b0 || ba.acc_data !== '0) begin
      bad++; $display("FAIL mid_acc_out enable=%b clear=%b data=%0d want all 0", ba.acc_enable, ba.acc_clear, ba.acc_data);
    end
    total++; if (ba.res_valid !== 1'b0 || ba.res_data !== '0) begin
      bad++; $display("FAIL mid_res_out valid=%b data=%0d want 0 and 0", ba.res_valid, ba.res_data);
    end
    total++; if (ba.fifo_count !== 4'd0 || ba.in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_fifo count=%0d in_ready=%b want 0 and 0", ba.fifo_count, ba.in_ready);
    end
    wait_cycles(2);
    reset_n = 1'b1;
    clear_logs();
    send_a(9, 1'b1);
    wait_cycles(10);
    total++;
    if (a_res.size() != 1) begin bad++; $display("FAIL mid_res_count got=%0d want=1", a_res.size()); end
    else if (a_res[0] != 9) begin bad++; $display("FAIL mid_res got=%0d want=9", a_res[0]); end
    total++; if (a_en_data.size() != 1) begin bad++; $display("FAIL mid_en_count got=%0d want=1", a_en_data.size()); end
  endtask

  task automatic test_no_autoclear();
    bb.res_ready = 1'b1;
    b_en_cyc.delete(); b_res.delete(); b_rise.delete();
    b_clr_cnt = 0;
    b_valid_cyc = 0;
    send_b(1, 1'b1);
    wait_cycles(10);
    send_b(2, 1'b1);
    wait_cycles(12);
    total++; if (b_clr_cnt != 0) begin bad++; $display("FAIL nac_clear got=%0d want=0", b_clr_cnt); end
    total++;
    if (b_res.size() != 2) begin bad++; $display("FAIL nac_res_count got=%0d want=2", b_res.size()); end
    else if (b_res[0] != 1 || b_res[1] != 3) begin bad++; $display("FAIL nac_res got=%0d,%0d want=1,3", b_res[0], b_res[1]); end
    total++;
    if (b_rise.size() != 2 || b_en_cyc.size() != 2) begin
      bad++; $display("FAIL nac_counts rise=%0d en=%0d want 2 and 2", b_rise.size(), b_en_cyc.size());
    end else begin
      total++; if (b_rise[0] - b_en_cyc[0] != 4) begin bad++; $display("FAIL nac_lat0 got=%0d want=4", b_rise[0] - b_en_cyc[0]); end
      total++; if (b_rise[1] - b_en_cyc[1] != 4) begin bad++; $display("FAIL nac_lat1 got=%0d want=4", b_rise[1] - b_en_cyc[1]); end
    end
    total++; if (b_valid_cyc != 2) begin bad++; $display("FAIL nac_valid_cycles got=%0d want=2", b_valid_cyc); end
  endtask

  initial begin
    ba.in_data = '0; ba.in_last = 1'b0; ba.in_valid = 1'b0; ba.res_ready = 1'b0;
    bb.in_data = '0; bb.in_last = 1'b0; bb.in_valid = 1'b0; bb.res_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_result_backpressure();
    test_fifo_full();
    test_reset_mid_frame();
    test_no_autoclear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
